// File: rtl/delay_line_var.sv
// rtl/delay_line_var.sv - run-time selectable multi-channel delay line with valid sideband and primed status
// Optional sticky out-of-range select flag (sel_err) is built when DELAY_LINE_ERR_EN is defined.
module delay_line_var #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int MAX_DELAY  = 7,
    parameter int SEL_W      = $clog2(MAX_DELAY + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           flush,
    input  logic [SEL_W-1:0]               delay_sel,
    input  logic                           valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
    output logic                           valid_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] Data_Out,
    output logic                           primed
`ifdef DELAY_LINE_ERR_EN
    ,
    output logic                           sel_err
`endif
);
    localparam int W = CHANNELS * DATA_WIDTH;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);

    logic [W-1:0]         stage_data [MAX_DELAY];
    logic [MAX_DELAY-1:0] stage_valid;
    logic [SEL_W-1:0]     fill_cnt;
    logic                 sel_over;
    logic [SEL_W-1:0]     eff_d;

    // Compared at 32 bits so the check stays meaningful when SEL_W covers exactly MAX_DELAY.
    assign sel_over = int'(delay_sel) > MAX_DELAY;
    assign eff_d    = sel_over ? MAX_SEL : delay_sel;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_data[i] <= '0;
            end
            stage_valid <= '0;
            fill_cnt    <= '0;
        end else if (en) begin
            stage_data[0]  <= Data_In;
            stage_valid[0] <= valid_in;
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_data[i]  <= stage_data[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
            if (fill_cnt != MAX_SEL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Tap mux straight off the stage registers; delay 0 is a combinational bypass.
    always_comb begin
        valid_out = valid_in;
        Data_Out  = Data_In;
        if (eff_d != '0) begin
            valid_out = 1'b0;
            Data_Out  = '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                if (eff_d == SEL_W'(i + 1)) begin
                    valid_out = stage_valid[i];
                    Data_Out  = stage_data[i];
                end
            end
        end
    end

    assign primed = (fill_cnt >= eff_d);

`ifdef DELAY_LINE_ERR_EN
    // Only reset clears the flag so that a transient bad select is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (sel_over) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// tb/tb_delay_line_var.sv - directed scoreboard bench for delay_line_var
module tb_delay_line_var;
    logic        clk = 1'b0;
    logic        reset, en, flush, valid_in;
    logic [2:0]  delay_sel, c_sel;
    logic [63:0] data_in;
    logic        valid_out, primed, c_valid_out, c_primed;
    logic [63:0] data_out, c_data_out;
`ifdef DELAY_LINE_ERR_EN
    logic        sel_err, c_sel_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [63:0] q[$];
    logic [63:0] hist [1:16];
    logic [63:0] exp_data;
    logic        exp_valid;
    int          en_cnt;

    always #5 clk = ~clk;

    delay_line_var dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .delay_sel(delay_sel),
        .valid_in(valid_in), .Data_In(data_in), .valid_out(valid_out),
        .Data_Out(data_out), .primed(primed)
`ifdef DELAY_LINE_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    delay_line_var #(.MAX_DELAY(5)) u_clamp (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .delay_sel(c_sel),
        .valid_in(valid_in), .Data_In(data_in), .valid_out(c_valid_out),
        .Data_Out(c_data_out), .primed(c_primed)
`ifdef DELAY_LINE_ERR_EN
        , .sel_err(c_sel_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; en = 1'b0; valid_in = 1'b0; data_in = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        delay_sel = 3'd7; c_sel = 3'd7;
        do_reset();
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data", data_out, 64'd0);
        check("rst_primed", 64'(primed), 64'd0);
`ifdef DELAY_LINE_ERR_EN
        check("rst_sel_err", 64'(sel_err), 64'd0);
`endif

        // Full-depth delay, incrementing words
        q.delete();
        en = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 64'h0001_0002_0003_0004 + 64'(k);
            q.push_back(data_in);
            step();
            if (k + 1 >= 7) begin
                check("d7_valid", 64'(valid_out), 64'd1);
                check("d7_primed", 64'(primed), 64'd1);
                if (q.size() > 0) check("d7_data", data_out, q.pop_front());
                else check("d7_queue", 64'(q.size()), 64'd1);
            end else begin
                check("d7_valid_early", 64'(valid_out), 64'd0);
                check("d7_primed_early", 64'(primed), 64'd0);
            end
        end

        // Stalls do not count toward latency; junk driven during stalls is ignored
        delay_sel = 3'd3;
        do_reset();
        q.delete();
        en_cnt = 0; exp_valid = 1'b0; exp_data = '0;
        for (int n = 0; n < 6; n++) begin
            en = (n % 2 == 0);
            if (!en) begin
                valid_in = 1'b1; data_in = 64'h1111_2222_3333_4444;
            end else if (n == 0) begin
                valid_in = 1'b1; data_in = {4{16'hAAAA}};
                q.push_back(data_in);
            end else begin
                valid_in = 1'b0; data_in = '0;
            end
            step();
            if (en) en_cnt++;
            if (en_cnt == 3 && en && q.size() > 0) begin
                exp_data = q.pop_front(); exp_valid = 1'b1;
            end
            check("stall_valid", 64'(valid_out), 64'(exp_valid));
            check("stall_data", data_out, exp_data);
        end

        // Zero delay is a combinational passthrough
        delay_sel = 3'd0;
        do_reset();
        check("d0_primed", 64'(primed), 64'd1);
        en = 1'b0; valid_in = 1'b1; data_in = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("d0_data", data_out, 64'h1234_5678_9ABC_DEF0);
        check("d0_valid", 64'(valid_out), 64'd1);
        valid_in = 1'b0; data_in = 64'h0F0F_0F0F_0F0F_0F0F;
        #1;
        check("d0_data2", data_out, 64'h0F0F_0F0F_0F0F_0F0F);
        check("d0_valid2", 64'(valid_out), 64'd0);

        // Flush with en=1 discards the incoming word and empties the line
        delay_sel = 3'd5;
        do_reset();
        en = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 64'h100 + 64'(k);
            step();
        end
        check("pre_flush_primed", 64'(primed), 64'd1);
        flush = 1'b1; data_in = '1;
        step();
        flush = 1'b0;
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_data", data_out, 64'd0);
        check("flush_primed", 64'(primed), 64'd0);
        valid_in = 1'b0; data_in = '0;
        for (int n = 1; n <= 6; n++) begin
            step();
            check("post_flush_data", data_out, 64'd0);
            check("post_flush_valid", 64'(valid_out), 64'd0);
            check("post_flush_primed", 64'(primed), 64'(n >= 5));
        end

        // Live delay change with a full line
        delay_sel = 3'd2;
        do_reset();
        en = 1'b1; valid_in = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            data_in = 64'hBEEF_0000 + 64'(n);
            hist[n] = data_in;
            step();
        end
        check("d2_data", data_out, hist[6]);
        en = 1'b0;
        delay_sel = 3'd6;
        #1;
        check("sw6_data", data_out, hist[2]);
        check("sw6_valid", 64'(valid_out), 64'd1);
        check("sw6_primed", 64'(primed), 64'd1);

        // Live delay change with only four samples stored
        delay_sel = 3'd2;
        do_reset();
        en = 1'b1; valid_in = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            data_in = 64'hCAFE_0000 + 64'(n);
            step();
        end
        check("fill4_primed", 64'(primed), 64'd1);
        en = 1'b0;
        delay_sel = 3'd6;
        #1;
        check("fill4_sw6_primed", 64'(primed), 64'd0);
        check("fill4_sw6_valid", 64'(valid_out), 64'd0);

        // Out-of-range select on a MAX_DELAY=5 instance clamps to 5
        c_sel = 3'd7;
        do_reset();
        en = 1'b1; valid_in = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            data_in = 64'h5000 + 64'(n);
            hist[n] = data_in;
            step();
            check("clamp_valid", 64'(c_valid_out), 64'(n >= 5));
            check("clamp_primed", 64'(c_primed), 64'(n >= 5));
            if (n >= 5) check("clamp_data", c_data_out, hist[n-4]);
        end
`ifdef DELAY_LINE_ERR_EN
        check("sel_err_set", 64'(c_sel_err), 64'd1);
        check("sel_err_main", 64'(sel_err), 64'd0);
        c_sel = 3'd2;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sel_err_flush", 64'(c_sel_err), 64'd1);
        do_reset();
        check("sel_err_reset", 64'(c_sel_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
